// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver clocked by the system clock: oversampled SPI pins,
// fixed-length frame assembly, field split and a show-ahead valid/ready FIFO.
`timescale 1ns/1ps
module spi_frame_rx #(
    parameter int unsigned FRAME_BITS   = 32,
    parameter int unsigned FIELD_W      = 10,
    parameter int unsigned FIELD_STRIDE = 16,
    parameter int unsigned NUM_FIELDS   = 2,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SAMPLE_RISE  = 1
) (
    input  logic                          clk,
    input  logic                          reset_b,
    input  logic                          sclk,
    input  logic                          sdo,
    input  logic                          cs_b,
    output logic                          sdi,
    output logic [FRAME_BITS-1:0]         frame_data,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FRAME_BITS);

    logic [2:0]            sclk_q;
    logic [1:0]            sdo_q;
    logic [1:0]            cs_q;
    logic [CW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] rx_next;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] last_frame;
    logic [FRAME_BITS-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;

    logic sclk_rise;
    logic sclk_fall;
    logic sample_edge;
    logic drive_edge;
    logic cs_act;
    logic frame_done;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic abort;

    always_comb begin
        sclk_rise   = sclk_q[1] & ~sclk_q[2];
        sclk_fall   = ~sclk_q[1] & sclk_q[2];
        sample_edge = (SAMPLE_RISE != 0) ? sclk_rise : sclk_fall;
        drive_edge  = (SAMPLE_RISE != 0) ? sclk_fall : sclk_rise;
        cs_act      = ~cs_q[1];
        rx_next     = {rx_sr[FRAME_BITS-2:0], sdo_q[1]};
        frame_done  = cs_act & sample_edge & (bit_cnt == CW'(FRAME_BITS - 1));
        fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        frame_valid = (wr_ptr != rd_ptr);
        pop         = frame_valid & frame_ready;
        // A full FIFO still accepts the frame when the head leaves in the same cycle.
        push        = frame_done & (~fifo_full | pop);
        drop        = frame_done & fifo_full & ~pop;
        abort       = ~cs_act & (bit_cnt != '0);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sclk_q <= '0;
            sdo_q  <= '0;
            cs_q   <= '1;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            sdo_q  <= {sdo_q[0], sdo};
            cs_q   <= {cs_q[0], cs_b};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            last_frame <= '0;
            sdi        <= 1'b0;
        end else begin
            if (!cs_act) begin
                bit_cnt <= '0;
                tx_sr   <= last_frame;
            end else begin
                if (sample_edge) begin
                    rx_sr   <= rx_next;
                    bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
                end
                if (drive_edge) begin
                    sdi   <= tx_sr[FRAME_BITS-1];
                    tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                end
            end
            if (push) begin
                last_frame <= rx_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= rx_next;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (abort) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign frame_data = mem[rd_ptr[AW-1:0]];

    always_comb begin
        fields = '0;
        for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
            fields[k*FIELD_W +: FIELD_W] = frame_data[k*FIELD_STRIDE +: FIELD_W];
        end
    end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Parametrised SPI slave receiver that replaces the SPI-clocked shift register and the ready-strobe latch with a single block clocked by the system clock. It oversamples `sclk`, `sdo` and `cs_b`, assembles fixed-length frames, and splits each frame into `NUM_FIELDS` fields. Frames are buffered in a small FIFO with a valid/ready handshake. The block sits between the external SPI master and the display/cursor logic; the default parameters reproduce the existing 32-bit frame that carries the x field in bits 25:16 and the y field in bits 9:0.

## Interface

Parameters:
- `FRAME_BITS`, default 32: bits per frame, range 8..64.
- `FIELD_W`, default 10: width of each field, at most `FIELD_STRIDE`.
- `FIELD_STRIDE`, default 16: bit spacing between field LSBs.
- `NUM_FIELDS`, default 2: number of fields; `NUM_FIELDS*FIELD_STRIDE` must not exceed `FRAME_BITS`.
- `DEPTH`, default 4: number of FIFO entries, a power of 2, at least 2.
- `SAMPLE_RISE`, default 1: 1 samples `sdo` on the `sclk` rising edge and drives `sdi` on the falling edge; 0 does the reverse.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `reset_b` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock from the master. Asynchronous to `clk`.
- `sdo` in 1: serial data from the master, MSB first.
- `cs_b` in 1: active-low chip select from the master.
- `sdi` out 1: serial data returned to the master.
- `frame_data` out FRAME_BITS: head-of-FIFO frame.
- `fields` out NUM_FIELDS*FIELD_W: field k is `frame_data[k*FIELD_STRIDE +: FIELD_W]`, packed at `fields[k*FIELD_W +: FIELD_W]`.
- `frame_valid` out 1: FIFO is not empty.
- `frame_ready` in 1: consumer accepts the head frame.
- `overflow` out 1: sticky flag; a completed frame was dropped because the FIFO was full.
- `frame_err` out 1: sticky flag; `cs_b` deasserted mid-frame.
- `clr_err` in 1: synchronous clear of both sticky flags.

## Operation

- `sclk`, `sdo` and `cs_b` each pass through a 2-flop synchronizer. A third `sclk` flop provides edge detection.
- `cs_b` high holds the bit counter at 0. It also reloads the transmit shift register with the last frame pushed, or 0 after reset.
- On a sample edge while `cs_b` is low:
  - the receive shift register loads `{rx[FRAME_BITS-2:0], sdo_s}`;
  - the bit counter increments.
- When the counter reaches `FRAME_BITS`, the assembled frame is pushed into the FIFO and the counter wraps to 0. Back-to-back frames under one `cs_b` assertion are therefore allowed.
- On a drive edge while `cs_b` is low, `sdi` shifts out the transmit register MSB first. This echoes the previous frame.
- Push rules:
  - FIFO not full: the frame is written.
  - FIFO full with no pop in the same cycle: the frame is discarded and `overflow` is set.
  - FIFO full with a pop in the same cycle: the frame is written and `overflow` is not set.
- Pop happens on `frame_valid && frame_ready`.
- The FIFO is show-ahead: `frame_data` and `fields` reflect the head entry combinationally from FIFO storage.
- `cs_b` rising while the counter is nonzero: the partial frame is discarded, `frame_err` is set, and the counter returns to 0.
- `clr_err` clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- Reset values:
  - `frame_valid`, `overflow`, `frame_err`, `sdi` are 0;
  - the FIFO is empty and its pointers are 0;
  - `frame_data` and `fields` are 0.
- Reset mid-frame discards the partial frame and all buffered frames.

## Timing

- `clk` must be at least 4 times `sclk`, so each `sclk` phase lasts at least 2 `clk` periods. `sdo` must be stable for 2 `clk` periods around the sample edge.
- Latency: let E0 be the `clk` edge at which the first synchronizer flop captures the final sample edge. `frame_valid` is high after edge E0+2.
- `sdi` changes 3 `clk` edges after the drive edge on the pin. The master must sample `sdi` at least half an `sclk` period later.
- A pop takes effect at the clock edge. `frame_valid` falls in the next cycle if the FIFO becomes empty.
- The FIFO count ranges 0..DEPTH and never wraps: pointers are `$clog2(DEPTH)+1` bits wide.

## Test plan

- Default parameters, one frame 0x03A5_0123 with `frame_ready`=0 → `frame_valid`=1, `fields[19:10]`=0x3A5, `fields[9:0]`=0x123. Then pulse `frame_ready` for one cycle → `frame_valid`=0.
- 5 back-to-back frames 0x1..0x5 under one `cs_b` with `frame_ready`=0 → 4 entries buffered and `overflow`=1. Pops return 0x1, 0x2, 0x3, 0x4 in order.
- FIFO full with `frame_ready`=1 held while the 5th frame completes → 5 frames are delivered in order and `overflow`=0.
- `cs_b` raised after 17 bits → `frame_err`=1, no push, and the next full frame 0xDEADBEEF is received intact. `clr_err` then clears `frame_err` to 0.
- Frame 0xCAFEF00D followed by a second frame → `sdi` during the second frame reads back 0xCAFEF00D MSB first. Repeat with `SAMPLE_RISE`=0.
- Assert `reset_b` low after 20 bits with 2 frames buffered → all outputs are 0 immediately. A subsequent full frame is received correctly.
